// File: rtl/lx_bus_requester.sv
// Bus-master requester: takes one line request from the cache, arbitrates for the bus,
// splits write-backs into beats and rebuilds read lines. Optional response timeout: REQ_TIMEOUT_EN.
module lx_bus_requester #(
  parameter int CACHE_OFFSET_BITS = 2,
  parameter int BUS_OFFSET_BITS   = 1,
  parameter int DATA_WIDTH        = 8,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int MSG_BITS          = 4,
  parameter int MAX_OFFSET_BITS   = 3,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter logic [MSG_BITS-1:0] NO_REQ   = MSG_BITS'(0),
  parameter logic [MSG_BITS-1:0] R_REQ    = MSG_BITS'(1),
  parameter logic [MSG_BITS-1:0] WB_REQ   = MSG_BITS'(2),
  parameter logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(3),
  localparam int LINE_W = DATA_WIDTH << CACHE_OFFSET_BITS,
  localparam int BEAT_W = DATA_WIDTH << BUS_OFFSET_BITS,
  localparam int OFF_W  = $clog2(MAX_OFFSET_BITS) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [MSG_BITS-1:0]      cache_msg_in,
  input  logic [ADDRESS_WIDTH-1:0] cache_address_in,
  input  logic [LINE_W-1:0]        cache_data_in,
  output logic [MSG_BITS-1:0]      cache_msg_out,
  output logic [ADDRESS_WIDTH-1:0] cache_address_out,
  output logic [LINE_W-1:0]        cache_data_out,
  output logic                     bus_request,
  input  logic                     bus_grant,
  output logic [MSG_BITS-1:0]      bus_msg_out,
  output logic [ADDRESS_WIDTH-1:0] bus_address_out,
  output logic [BEAT_W-1:0]        bus_data_out,
  output logic [OFF_W-1:0]         req_offset,
  output logic                     req_ready,
  input  logic [MSG_BITS-1:0]      bus_msg_in,
  input  logic [ADDRESS_WIDTH-1:0] bus_address_in,
  input  logic [BEAT_W-1:0]        bus_data_in
);

  localparam int BEATS = 1 << (CACHE_OFFSET_BITS - BUS_OFFSET_BITS);
  localparam int CNT_W = (CACHE_OFFSET_BITS == BUS_OFFSET_BITS) ? 1 : CACHE_OFFSET_BITS - BUS_OFFSET_BITS;
  localparam int ALIGN = CACHE_OFFSET_BITS + $clog2(DATA_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = {ADDRESS_WIDTH{1'b1}} << ALIGN;

  typedef enum logic [2:0] {IDLE, WAIT_GRANT, SEND_DATA, WAIT_RESP, RECV_DATA, RESP_CACHE} state_t;

  typedef struct packed {
    logic [MSG_BITS-1:0]            msg;
    logic [ADDRESS_WIDTH-1:0]       addr;
    logic [BEATS-1:0][BEAT_W-1:0]   line;
  } req_t;

  state_t                   state_q, state_n;
  req_t                     req_q, req_n;
  logic [CNT_W-1:0]         cnt_q, cnt_n;
  logic                     last_beat;

  logic [MSG_BITS-1:0]      cache_msg_n;
  logic [ADDRESS_WIDTH-1:0] cache_address_n;
  logic [LINE_W-1:0]        cache_data_n;
  logic                     bus_request_n;
  logic [MSG_BITS-1:0]      bus_msg_n;
  logic [ADDRESS_WIDTH-1:0] bus_address_n;
  logic [BEAT_W-1:0]        bus_data_n;
  logic [OFF_W-1:0]         req_offset_n;
  logic                     req_ready_n;

`ifdef REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_n;
`endif

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_n         = state_q;
    req_n           = req_q;
    cnt_n           = cnt_q;
    cache_msg_n     = cache_msg_out;
    cache_address_n = cache_address_out;
    cache_data_n    = cache_data_out;
    bus_request_n   = bus_request;
    bus_msg_n       = bus_msg_out;
    bus_address_n   = bus_address_out;
    bus_data_n      = bus_data_out;
    req_offset_n    = req_offset;
    req_ready_n     = req_ready;
`ifdef REQ_TIMEOUT_EN
    tcnt_n          = tcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cache_msg_in == R_REQ || cache_msg_in == WB_REQ) begin
          req_n.msg     = cache_msg_in;
          req_n.addr    = cache_address_in & ALIGN_MASK;
          req_n.line    = cache_data_in;
          bus_request_n = 1'b1;
          state_n       = WAIT_GRANT;
        end
      end
      WAIT_GRANT: begin
        bus_request_n = 1'b1;
        // a grant seen while the request is dropped (timeout gap) is not ours
        if (bus_grant && bus_request) begin
          bus_msg_n     = req_q.msg;
          bus_address_n = req_q.addr;
          req_offset_n  = OFF_W'(CACHE_OFFSET_BITS);
          req_ready_n   = 1'b1;
          cnt_n         = '0;
`ifdef REQ_TIMEOUT_EN
          tcnt_n        = '0;
`endif
          state_n       = (req_q.msg == WB_REQ) ? SEND_DATA : WAIT_RESP;
        end
      end
      SEND_DATA: begin
        bus_data_n = req_q.line[cnt_q];
        cnt_n      = last_beat ? '0 : cnt_q + 1'b1;
        if (last_beat) state_n = WAIT_RESP;
      end
      WAIT_RESP: begin
        bus_data_n = '0;
        if (bus_msg_in == MEM_RESP && bus_address_in == req_q.addr) begin
          if (req_q.msg == R_REQ) begin
            cnt_n   = '0;
            state_n = RECV_DATA;
          end else begin
            bus_request_n   = 1'b0;
            bus_msg_n       = NO_REQ;
            bus_address_n   = '0;
            req_offset_n    = '0;
            req_ready_n     = 1'b0;
            cache_msg_n     = MEM_RESP;
            cache_address_n = req_q.addr;
            cache_data_n    = '0;
            state_n         = RESP_CACHE;
          end
        end
`ifdef REQ_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          bus_request_n = 1'b0;
          bus_msg_n     = NO_REQ;
          bus_address_n = '0;
          req_offset_n  = '0;
          req_ready_n   = 1'b0;
          state_n       = WAIT_GRANT;
        end else begin
          tcnt_n = tcnt_q + 1'b1;
        end
`endif
      end
      RECV_DATA: begin
        req_n.line[cnt_q] = bus_data_in;
        cnt_n             = last_beat ? '0 : cnt_q + 1'b1;
        if (last_beat) begin
          bus_request_n   = 1'b0;
          bus_msg_n       = NO_REQ;
          bus_address_n   = '0;
          req_offset_n    = '0;
          req_ready_n     = 1'b0;
          cache_msg_n     = MEM_RESP;
          cache_address_n = req_q.addr;
          cache_data_n    = req_n.line;
          state_n         = RESP_CACHE;
        end
      end
      RESP_CACHE: begin
        if (cache_msg_in == NO_REQ) begin
          cache_msg_n     = NO_REQ;
          cache_address_n = '0;
          cache_data_n    = '0;
          state_n         = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= IDLE;
      req_q             <= '0;
      cnt_q             <= '0;
      cache_msg_out     <= NO_REQ;
      cache_address_out <= '0;
      cache_data_out    <= '0;
      bus_request       <= 1'b0;
      bus_msg_out       <= NO_REQ;
      bus_address_out   <= '0;
      bus_data_out      <= '0;
      req_offset        <= '0;
      req_ready         <= 1'b0;
`ifdef REQ_TIMEOUT_EN
      tcnt_q            <= '0;
`endif
    end else begin
      state_q           <= state_n;
      req_q             <= req_n;
      cnt_q             <= cnt_n;
      cache_msg_out     <= cache_msg_n;
      cache_address_out <= cache_address_n;
      cache_data_out    <= cache_data_n;
      bus_request       <= bus_request_n;
      bus_msg_out       <= bus_msg_n;
      bus_address_out   <= bus_address_n;
      bus_data_out      <= bus_data_n;
      req_offset        <= req_offset_n;
      req_ready         <= req_ready_n;
`ifdef REQ_TIMEOUT_EN
      tcnt_q            <= tcnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_lx_bus_requester.sv
// Directed bench for lx_bus_requester: read, write-back, stray response, held cache handshake,
// mid-transfer reset and (with REQ_TIMEOUT_EN) timeout replay.
module tb_lx_bus_requester;
  localparam logic [3:0] NO_REQ = 4'd0, R_REQ = 4'd1, WB_REQ = 4'd2, MEM_RESP = 4'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cache_msg_in = NO_REQ;
  logic [31:0] cache_address_in = '0;
  logic [31:0] cache_data_in = '0;
  logic [3:0]  cache_msg_out;
  logic [31:0] cache_address_out;
  logic [31:0] cache_data_out;
  logic        bus_request;
  logic        bus_grant = 1'b0;
  logic [3:0]  bus_msg_out;
  logic [31:0] bus_address_out;
  logic [15:0] bus_data_out;
  logic [2:0]  req_offset;
  logic        req_ready;
  logic [3:0]  bus_msg_in = NO_REQ;
  logic [31:0] bus_address_in = '0;
  logic [15:0] bus_data_in = '0;

  int total = 0;
  int bad   = 0;

  lx_bus_requester #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .cache_msg_in(cache_msg_in), .cache_address_in(cache_address_in), .cache_data_in(cache_data_in),
    .cache_msg_out(cache_msg_out), .cache_address_out(cache_address_out), .cache_data_out(cache_data_out),
    .bus_request(bus_request), .bus_grant(bus_grant),
    .bus_msg_out(bus_msg_out), .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
    .req_offset(req_offset), .req_ready(req_ready),
    .bus_msg_in(bus_msg_in), .bus_address_in(bus_address_in), .bus_data_in(bus_data_in)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] msg, input logic [31:0] addr, input logic [31:0] data);
    cache_msg_in = msg; cache_address_in = addr; cache_data_in = data;
    step(1);
    cache_msg_in = NO_REQ; cache_address_in = '0; cache_data_in = '0;
  endtask

  task automatic grant;
    bus_grant = 1'b1;
    step(1);
    bus_grant = 1'b0;
  endtask

  task automatic resp(input logic [31:0] addr);
    bus_msg_in = MEM_RESP; bus_address_in = addr;
    step(1);
    bus_msg_in = NO_REQ; bus_address_in = '0;
  endtask

  task automatic beats(input logic [15:0] b0, input logic [15:0] b1);
    bus_data_in = b0; step(1);
    bus_data_in = b1; step(1);
    bus_data_in = '0;
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    chk("rst_req", bus_request, 0);
    chk("rst_bmsg", bus_msg_out, NO_REQ);
    chk("rst_cmsg", cache_msg_out, NO_REQ);
    chk("rst_rdy", req_ready, 0);

    // unsupported message is ignored in IDLE
    issue(4'hF, 32'h1234_5678, '0);
    chk("ign_req", bus_request, 0);

    // 1: read, grant on the third cycle
    issue(R_REQ, 32'h1111_0006, '0);
    chk("rd_req", bus_request, 1);
    chk("rd_nomsg", bus_msg_out, NO_REQ);
    step(2);
    chk("rd_wait", bus_msg_out, NO_REQ);
    grant();
    chk("rd_bmsg", bus_msg_out, R_REQ);
    chk("rd_baddr", bus_address_out, 32'h1111_0004);
    chk("rd_off", req_offset, 2);
    chk("rd_rdy", req_ready, 1);
    step(2);
    chk("rd_hold", req_ready, 1);
    resp(32'h1111_0004);
    beats(16'h2211, 16'h4433);
    chk("rd_cmsg", cache_msg_out, MEM_RESP);
    chk("rd_cdata", cache_data_out, 32'h4433_2211);
    chk("rd_caddr", cache_address_out, 32'h1111_0004);
    chk("rd_rel_msg", bus_msg_out, NO_REQ);
    chk("rd_rel_rdy", req_ready, 0);
    chk("rd_rel_req", bus_request, 0);
    step(1);
    chk("rd_done", cache_msg_out, NO_REQ);

    // 2: write-back, beats on consecutive cycles
    issue(WB_REQ, 32'h8000_4488, 32'h8877_6655);
    grant();
    chk("wb_bmsg", bus_msg_out, WB_REQ);
    chk("wb_baddr", bus_address_out, 32'h8000_4488);
    chk("wb_d_pre", bus_data_out, 0);
    step(1);
    chk("wb_beat0", bus_data_out, 16'h6655);
    step(1);
    chk("wb_beat1", bus_data_out, 16'h8877);
    step(1);
    chk("wb_d_post", bus_data_out, 0);
    chk("wb_rdy", req_ready, 1);
    resp(32'h8000_4488);
    chk("wb_rel_req", bus_request, 0);
    chk("wb_rel_msg", bus_msg_out, NO_REQ);
    chk("wb_cmsg", cache_msg_out, MEM_RESP);
    chk("wb_caddr", cache_address_out, 32'h8000_4488);
    step(1);
    chk("wb_done", cache_msg_out, NO_REQ);

    // 3: response with the wrong address is ignored
    issue(R_REQ, 32'h1111_0004, '0);
    grant();
    resp(32'h1111_0008);
    chk("mis_rdy", req_ready, 1);
    chk("mis_bmsg", bus_msg_out, R_REQ);
    step(2);
    chk("mis_cmsg", cache_msg_out, NO_REQ);
    resp(32'h1111_0004);
    beats(16'hBBAA, 16'hDDCC);
    chk("mis_cdata", cache_data_out, 32'hDDCC_BBAA);
    step(1);

    // 4: cache keeps R_REQ for 5 cycles in the response state
    cache_msg_in = R_REQ; cache_address_in = 32'h0000_0010;
    step(1);
    grant();
    resp(32'h0000_0010);
    beats(16'h0001, 16'h0002);
    chk("hold_c1", cache_msg_out, MEM_RESP);
    step(4);
    chk("hold_c5", cache_msg_out, MEM_RESP);
    chk("hold_data", cache_data_out, 32'h0002_0001);
    cache_msg_in = NO_REQ; cache_address_in = '0;
    step(1);
    chk("hold_clr", cache_msg_out, NO_REQ);
    chk("hold_idle", bus_request, 0);

    // 5: reset in the middle of a write-back
    issue(WB_REQ, 32'h8000_4488, 32'h8877_6655);
    grant();
    step(1);
    chk("rst_wb_b0", bus_data_out, 16'h6655);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_wb_req", bus_request, 0);
    chk("rst_wb_msg", bus_msg_out, NO_REQ);
    chk("rst_wb_data", bus_data_out, 0);
    chk("rst_wb_rdy", req_ready, 0);
    issue(R_REQ, 32'h3333_0003, '0);
    grant();
    chk("rst_rd_addr", bus_address_out, 32'h3333_0000);
    resp(32'h3333_0000);
    beats(16'h1234, 16'h5678);
    chk("rst_rd_data", cache_data_out, 32'h5678_1234);
    step(1);

`ifdef REQ_TIMEOUT_EN
    // 6: no response -> drop for a cycle, re-request, replay beats
    issue(WB_REQ, 32'h4000_0000, 32'hCAFE_BEEF);
    grant();
    step(2);
    chk("to_beat1", bus_data_out, 16'hCAFE);
    step(7);
    chk("to_held", bus_request, 1);
    step(1);
    chk("to_drop_req", bus_request, 0);
    chk("to_drop_msg", bus_msg_out, NO_REQ);
    chk("to_drop_rdy", req_ready, 0);
    step(1);
    chk("to_rereq", bus_request, 1);
    grant();
    chk("to_remsg", bus_msg_out, WB_REQ);
    step(1);
    chk("to_rb0", bus_data_out, 16'hBEEF);
    step(1);
    chk("to_rb1", bus_data_out, 16'hCAFE);
    resp(32'h4000_0000);
    chk("to_cmsg", cache_msg_out, MEM_RESP);
    step(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
